// File: rtl/mem_arbiter.sv
// Two-port (write/read) arbiter in front of a single-ported memory wrapper.
// Each access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> DONE; ties resolved round-robin.
module mem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 4,
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned DATA_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dW,
  output logic              mem_RE,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_dR,
  output logic              busy
);

  localparam int unsigned    CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
  typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} grant_e;

  state_e            state_q, state_d;
  grant_e            last_q, last_d;   // last grant; also the owner of the access in flight
  grant_e            pick_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dw_q, dw_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              wack_q, wack_d;
  logic              rvalid_q, rvalid_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= GNT_RD;
      cnt_q    <= '0;
      addr_q   <= '0;
      dw_q     <= '0;
      rdata_q  <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      wack_q   <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dw_q     <= dw_d;
      rdata_q  <= rdata_d;
      re_q     <= re_d;
      we_q     <= we_d;
      wack_q   <= wack_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
    end
  end

  // Strobes and pulses are computed for the next cycle so every output comes from a flop.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dw_d     = dw_q;
    rdata_d  = rdata_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    wack_d   = 1'b0;
    rvalid_d = 1'b0;
    pick_c   = (wr_req && (!rd_req || last_q == GNT_RD)) ? GNT_WR : GNT_RD;

    case (state_q)
      IDLE: begin
        if (wr_req || rd_req) begin
          state_d = SETUP;
          last_d  = pick_c;
          if (pick_c == GNT_WR) begin
            addr_d = wr_addr;
            dw_d   = wr_data;
          end else begin
            addr_d = rd_addr;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_LOAD;
        re_d    = (last_q == GNT_RD);
        we_d    = (last_q == GNT_WR);
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          wack_d   = (last_q == GNT_WR);
          rvalid_d = (last_q == GNT_RD);
          if (last_q == GNT_RD) begin
            rdata_d = mem_dR;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          re_d  = (last_q == GNT_RD);
          we_d  = (last_q == GNT_WR);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign mem_addr = addr_q;
  assign mem_dW   = dw_q;
  assign mem_RE   = re_q;
  assign mem_WE   = we_q;
  assign rd_data  = rdata_q;
  assign wr_ack   = wack_q;
  assign rd_valid = rvalid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, multi-cycle corner sequences,
// then randomized requesters checked cycle-by-cycle against a timing-level model.
module tb_mem_arbiter;

  localparam int AC = 4;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  typedef struct {
    logic        wr;
    logic        drop;
    logic [23:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req, rd_req;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack, rd_valid, mem_RE, mem_WE, busy;
  logic [DATA_W-1:0] rd_data, mem_dW, mem_dR;
  logic [ADDR_W-1:0] mem_addr;

  logic [15:0] mem_m [256];
  logic        mem_init;
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] last_rd;

  mem_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_addr(mem_addr), .mem_dW(mem_dW), .mem_RE(mem_RE), .mem_WE(mem_WE),
    .mem_dR(mem_dR), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory wrapper model: aliases on the low address byte, seeded with a known pattern.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_m[i] <= 16'(i * 16'h0101) ^ 16'h5A5A;
    end else if (mem_WE) begin
      mem_m[mem_addr[7:0]] <= mem_dW;
    end
  end
  assign mem_dR = mem_m[mem_addr[7:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) check("re_we_exclusive", 64'(mem_RE & mem_WE), 64'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({mem_RE, mem_WE, wr_ack, rd_valid, busy, mem_addr, mem_dW, rd_data}), 64'(0));
    last_rd = 16'h0000;
  endtask

  // One request from an idle DUT; inputs are scrambled mid-access to prove they are ignored.
  task automatic do_txn(input txn_t t, input string tag);
    int lat = -1;
    int n_re = 0, n_we = 0, n_bad = 0, n_wack = 0, n_rv = 0;
    logic [15:0] rd_at_ack = 16'h0;
    if (t.wr) begin wr_req = 1'b1; wr_addr = t.addr; wr_data = t.data; end
    else begin rd_req = 1'b1; rd_addr = t.addr; end
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1 && t.drop) begin wr_req = 1'b0; rd_req = 1'b0; end
      if (n == 3) begin wr_addr = 24'($urandom); wr_data = 16'($urandom); rd_addr = 24'($urandom); end
      @(negedge clk);
      if (mem_RE) n_re++;
      if (mem_WE) n_we++;
      if ((mem_RE || mem_WE) && (mem_addr !== t.addr || (t.wr && mem_dW !== t.data))) n_bad++;
      if (wr_ack) n_wack++;
      if (rd_valid) n_rv++;
      if ((wr_ack || rd_valid) && lat < 0) begin
        lat = n; rd_at_ack = rd_data; wr_req = 1'b0; rd_req = 1'b0;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(AC + 2));
    check({tag, " re_cycles"}, 64'(n_re), 64'(t.wr ? 0 : AC));
    check({tag, " we_cycles"}, 64'(n_we), 64'(t.wr ? AC : 0));
    check({tag, " addr_data_stable"}, 64'(n_bad), 64'(0));
    check({tag, " wr_ack_count"}, 64'(n_wack), 64'(t.wr ? 1 : 0));
    check({tag, " rd_valid_count"}, 64'(n_rv), 64'(t.wr ? 0 : 1));
    if (!t.wr) begin
      check({tag, " rd_data_at_valid"}, 64'(rd_at_ack), 64'(t.exp_rd));
      last_rd = t.exp_rd;
    end
    check({tag, " rd_data_held"}, 64'(rd_data), 64'(last_rd));
    check({tag, " idle_after"}, 64'(busy), 64'(0));
  endtask

  txn_t tbl[9];

  initial begin
    // Model state for the randomized phase
    int s, free_at, rel;
    logic g_wr, last_wr, pend_w, pend_r, seen_w, seen_r;
    logic [23:0] addr_m;
    logic [15:0] dw_m, rdq, rd_pend;
    logic [63:0] exp_v, act_v;
    logic e_busy, e_re, e_we, e_wack, e_rv;
    int ack_log[$];
    int exp_log[4];
    int n_re_after, n_we_after, n_ack_after;

    tbl[0] = '{1'b1, 1'b0, 24'h000123, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 24'h000123, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b0, 24'hABCD45, 16'h1234, 16'h0000};
    tbl[3] = '{1'b0, 1'b1, 24'hABCD45, 16'h0000, 16'h1234};
    tbl[4] = '{1'b0, 1'b0, 24'h000007, 16'h0000, 16'h5D5D};
    tbl[5] = '{1'b1, 1'b0, 24'hFFFFFF, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 1'b0, 24'hFFFFFF, 16'h0000, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 24'h000000, 16'hFFFF, 16'h0000};
    tbl[8] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 16'hFFFF};

    rst = 1'b1; mem_init = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (2) step();
    mem_init = 1'b0;

    reset_dut();
    for (int i = 0; i < 9; i++) do_txn(tbl[i], $sformatf("txn%0d", i));

    // Both requesters held: write wins first after reset, then strict alternation every AC+3 cycles.
    reset_dut();
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 24'h111111; wr_data = 16'h1111; rd_addr = 24'h222222;
    for (int n = 1; n <= 30; n++) begin
      step();
      @(negedge clk);
      if (wr_ack) ack_log.push_back(n * 2 + 1);
      if (rd_valid) ack_log.push_back(n * 2);
    end
    exp_log[0] = (AC + 2) * 2 + 1;
    exp_log[1] = (2 * AC + 5) * 2;
    exp_log[2] = (3 * AC + 8) * 2 + 1;
    exp_log[3] = (4 * AC + 11) * 2;
    check("tie ack_count", 64'(ack_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check($sformatf("tie grant%0d cycle_and_kind", i), 64'(ack_log[i]), 64'(exp_log[i]));
    wr_req = 1'b0; rd_req = 1'b0;
    for (int n = 0; n < 40 && busy; n++) step();
    check("tie drain", 64'(busy), 64'(0));

    // Reset landing on the second ACCESS cycle of a write.
    step();
    wr_req = 1'b1; wr_addr = 24'h000099; wr_data = 16'hCAFE;
    repeat (3) step();
    @(negedge clk);
    check("abort we_before_reset", 64'(mem_WE), 64'(1));
    rst = 1'b1; wr_req = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort reset_outputs", 64'({mem_RE, mem_WE, wr_ack, rd_valid, busy, mem_addr, mem_dW, rd_data}), 64'(0));
    last_rd = 16'h0000;
    n_re_after = 0; n_we_after = 0; n_ack_after = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      @(negedge clk);
      if (mem_RE) n_re_after++;
      if (mem_WE) n_we_after++;
      if (wr_ack || rd_valid) n_ack_after++;
    end
    check("abort no_strobe_after", 64'(n_re_after + n_we_after), 64'(0));
    check("abort no_ack_after", 64'(n_ack_after), 64'(0));
    step();
    do_txn('{1'b0, 1'b0, 24'h000055, 16'h0000, 16'h0F0F}, "abort_then_read");

    // Randomized requesters against a model expressed as access start times and windows.
    reset_dut();
    s = -1000; free_at = 0; last_wr = 1'b0; addr_m = '0; dw_m = '0; rdq = '0; rd_pend = '0; g_wr = 1'b0;
    pend_w = 1'b0; pend_r = 1'b0; seen_w = 1'b0; seen_r = 1'b0;
    for (int t = 1; t <= 600; t++) begin
      step();
      if (seen_w || $urandom_range(0, 15) == 0) pend_w = 1'b0;
      else if (!pend_w && $urandom_range(0, 2) == 0) pend_w = 1'b1;
      if (seen_r || $urandom_range(0, 15) == 0) pend_r = 1'b0;
      else if (!pend_r && $urandom_range(0, 2) == 0) pend_r = 1'b1;
      if (seen_w && $urandom_range(0, 3) == 0) pend_w = 1'b1;
      if (seen_r && $urandom_range(0, 3) == 0) pend_r = 1'b1;
      wr_req = pend_w; rd_req = pend_r;
      wr_addr = 24'($urandom); wr_data = 16'($urandom); rd_addr = 24'($urandom);
      @(negedge clk);
      seen_w = wr_ack; seen_r = rd_valid;
      rel = t - s;
      e_busy = (rel >= 0 && rel <= AC + 1);
      e_we = g_wr && rel >= 1 && rel <= AC;
      e_re = !g_wr && rel >= 1 && rel <= AC;
      e_wack = g_wr && rel == AC + 1;
      e_rv = !g_wr && rel == AC + 1;
      if (e_rv) rdq = rd_pend;
      exp_v = 64'({e_busy, e_re, e_we, e_wack, e_rv, rdq, addr_m, dw_m});
      act_v = 64'({busy, mem_RE, mem_WE, wr_ack, rd_valid, rd_data, mem_addr, mem_dW});
      check($sformatf("rand cyc%0d {busy,re,we,wack,rv,rd,addr,dw}", t), act_v, exp_v);
      if (t >= free_at && (wr_req || rd_req)) begin
        g_wr = wr_req && (!rd_req || !last_wr);
        last_wr = g_wr;
        s = t + 1;
        free_at = t + AC + 3;
        if (g_wr) begin addr_m = wr_addr; dw_m = wr_data; end
        else begin addr_m = rd_addr; rd_pend = mem_m[rd_addr[7:0]]; end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    for (int n = 0; n < 40 && busy; n++) step();
    check("rand drain", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameters SHALL be:
- ACCESS_CYCLES, default 4, number of cycles RE/WE is held high; legal range 1..255.
- ADDR_W, default 24, address width.
- DATA_W, default 16, data width.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_req  in  1  write request, held until wr_ack
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle write-complete pulse
- rd_req  in  1  read request, held until rd_valid
- rd_addr  in  ADDR_W  read word address
- rd_data  out  DATA_W  read data, registered
- rd_valid  out  1  one-cycle read-complete pulse
- mem_addr  out  ADDR_W  to memory wrapper addr
- mem_dW  out  DATA_W  to memory wrapper dW
- mem_RE  out  1  to memory wrapper RE
- mem_WE  out  1  to memory wrapper WE
- mem_dR  in  DATA_W  from memory wrapper dR
- busy  out  1  high in any state other than IDLE

Function
REQ-004 The FSM SHALL have four states: IDLE, SETUP, ACCESS and DONE.
REQ-005 In IDLE with exactly one request high, the FSM SHALL grant that requester, latch its address (and its data for writes) into mem_addr and mem_dW, and go to SETUP.
REQ-006 In IDLE with both requests high, the FSM SHALL grant the requester not granted last (round-robin); last_grant resets to "read", so write wins the first tie after reset.
REQ-007 In IDLE with no request, the FSM SHALL remain in IDLE and mem_addr/mem_dW SHALL hold their values.
REQ-008 SETUP SHALL last exactly 1 cycle, with the address stable and mem_RE and mem_WE both low.
REQ-009 ACCESS SHALL last exactly ACCESS_CYCLES cycles:
- mem_WE is high for a write grant; mem_RE is high for a read grant.
- An 8-bit down-counter, loaded with ACCESS_CYCLES-1 on entry, sets the duration.
REQ-010 On the last ACCESS cycle of a read, mem_dR SHALL be captured into rd_data.
REQ-011 DONE SHALL last 1 cycle:
- mem_RE and mem_WE are low.
- wr_ack or rd_valid pulses for the granted requester only.
- The next state is IDLE.
REQ-012 Latency SHALL be ACCESS_CYCLES+2 cycles from the edge that samples the request in IDLE to the ack/valid cycle; back-to-back requests SHALL add 1 IDLE cycle, giving ACCESS_CYCLES+3 cycles per access.
REQ-013 mem_RE and mem_WE SHALL never be high in the same cycle and SHALL be low outside ACCESS.
REQ-014 mem_addr and mem_dW SHALL stay constant from SETUP through DONE.
REQ-015 Request, address and data inputs SHALL be ignored outside IDLE; a request that drops before its ack SHALL still complete.
REQ-016 rd_data SHALL hold its value until the next read completes.
REQ-017 A requester that keeps its request high in the IDLE cycle after its ack SHALL be treated as a new request.

Reset
REQ-018 With rst high at a clock edge, the next cycle SHALL show all of the following:
- state IDLE
- mem_RE = 0 and mem_WE = 0
- mem_addr = 0 and mem_dW = 0
- rd_data = 0
- wr_ack = 0, rd_valid = 0, busy = 0
- last_grant = read
- counter = 0
REQ-019 A reset during SETUP, ACCESS or DONE SHALL abort the access with no ack or valid pulse, and no RE/WE pulse SHALL be emitted afterward.

Verification (ACCESS_CYCLES=4)
REQ-020 Single write, wr_addr=0x000123, wr_data=0xBEEF: SETUP 1 cycle, mem_WE high for exactly 4 cycles with mem_addr=0x000123 and mem_dW=0xBEEF, wr_ack pulses 6 cycles after the request is sampled.
REQ-021 Single read, rd_addr=0x000123, with the memory model returning 0xBEEF: mem_RE high for 4 cycles, rd_valid pulses with rd_data=0xBEEF, and rd_data still reads 0xBEEF 10 cycles later.
REQ-022 wr_req and rd_req raised in the same cycle after reset: write served first, then read; with both held continuously, grants alternate W,R,W,R and each access takes 7 cycles.
REQ-023 rst asserted on the 2nd ACCESS cycle of a write: mem_WE is low on the next cycle, no wr_ack is produced, and a following read completes normally.
REQ-024 wr_addr and wr_data changed during ACCESS: mem_addr and mem_dW keep the values latched at grant.
REQ-025 Checker over all tests: mem_RE & mem_WE is never 1, and at most one ack/valid pulse occurs per grant.
